// File: rtl/linear_array_scan_ctrl.sv
// Linear image-sensor scan controller: SI pulse, N_PIXELS ADC conversions, optional integration wait.
// Define DISCARD_FIRST_FRAME_EN to suppress reporting of the first frame after leaving IDLE.
module linear_array_scan_ctrl #(
  parameter int unsigned N_PIXELS = 128,
  parameter int unsigned INTEG_W  = 16
) (
  input  logic               sensor_clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [INTEG_W-1:0] integ_extra,
  output logic               si_out,
  output logic               adc_conv,
  output logic [6:0]         pixel_idx,
  output logic               pixel_valid,
  output logic               frame_done,
  output logic               busy,
  output logic [15:0]        frame_cnt
);

  typedef enum logic [1:0] {IDLE, SI, READ, WAIT} state_t;

  localparam logic [6:0] LAST = 7'(N_PIXELS - 1);

  state_t             state, state_n;
  logic [INTEG_W-1:0] wait_cnt, wait_cnt_n;
  logic [6:0]         idx_n;
  logic               last_pix;
  logic               discard;
  logic               cnt_inc;

  assign last_pix = (state == READ) && (pixel_idx == LAST);

`ifdef DISCARD_FIRST_FRAME_EN
  // Frame started from IDLE has an undefined integration time; flag it until its last pixel.
  always_ff @(negedge sensor_clk or negedge reset_n) begin
    if (!reset_n) begin
      discard <= 1'b0;
    end else if (state == IDLE && enable) begin
      discard <= 1'b1;
    end else if (last_pix) begin
      discard <= 1'b0;
    end
  end
`else
  assign discard = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    wait_cnt_n = wait_cnt;
    idx_n      = pixel_idx;
    case (state)
      IDLE: begin
        idx_n = '0;
        if (enable) state_n = SI;
      end
      SI: begin
        idx_n      = '0;
        wait_cnt_n = integ_extra;
        state_n    = READ;
      end
      READ: begin
        if (pixel_idx == LAST) begin
          if (wait_cnt != '0) begin
            state_n = WAIT;
          end else begin
            state_n = enable ? SI : IDLE;
            idx_n   = '0;
          end
        end else begin
          idx_n = pixel_idx + 7'd1;
        end
      end
      WAIT: begin
        wait_cnt_n = wait_cnt - INTEG_W'(1);
        if (wait_cnt == INTEG_W'(1)) begin
          state_n = enable ? SI : IDLE;
          idx_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
    // Counter steps on the edge entering the last pixel so it moves together with frame_done.
    cnt_inc = (state_n == READ) && (idx_n == LAST) && !discard;
  end

  always_ff @(negedge sensor_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      pixel_idx <= '0;
      frame_cnt <= '0;
    end else begin
      state     <= state_n;
      wait_cnt  <= wait_cnt_n;
      pixel_idx <= idx_n;
      if (cnt_inc) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign si_out      = (state == SI);
  assign adc_conv    = (state == READ);
  assign pixel_valid = adc_conv && !discard;
  assign frame_done  = last_pix && !discard;
  assign busy        = (state != IDLE);

endmodule
